ir_queue: RTL and testbench

IR_QUEUE -- requirements
Module: ir_queue

---
 rtl/ir_queue_if.sv | 29 ++
 rtl/ir_queue.sv | 118 +++++++++++
 tb/tb_ir_queue.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ir_queue_if.sv
// Opcode queue bus: producer/consumer side (master) and queue side (slave).
interface ir_queue_if #(
  parameter int unsigned OP_W  = 6,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic            loadIR;
  logic [OP_W-1:0] inop;
  logic            inpar;
  logic            next;
  logic            flush;
  logic [OP_W-1:0] opcode;
  logic            valid;
  logic            full;
  logic [CW-1:0]   count;
  logic            ovf;
  logic            perr;

  modport master (
    output loadIR, inop, inpar, next, flush,
    input  opcode, valid, full, count, ovf, perr
  );

  modport slave (
    input  loadIR, inop, inpar, next, flush,
    output opcode, valid, full, count, ovf, perr
  );
endinterface

// File: rtl/ir_queue.sv
// ir_queue: DEPTH-entry FIFO of OP_W-bit opcodes feeding the decoder.
// The head entry is visible one cycle after it is loaded into an empty queue.
// Optional feature macro: IR_PARITY_EN stores an even-parity bit per entry
// and reports a parity error on the head; without it perr is tied low.
module ir_queue #(
  parameter int unsigned OP_W  = 6,
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  ir_queue_if.slave  bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [OP_W-1:0] mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;
  logic            ovf_q;

  logic            is_valid;
  logic            is_full;
  logic            pop;
  logic            push;
  logic            drop;
  logic [PW-1:0]   wr_ptr_nxt;
  logic [PW-1:0]   rd_ptr_nxt;
  logic [CW-1:0]   cnt_nxt;
  logic            ovf_nxt;

  // Handshake qualification: pop needs data, push needs room or a same-cycle pop.
  always_comb begin
    is_valid = (cnt != '0);
    is_full  = (cnt == CW'(DEPTH));
    pop      = bus.next & is_valid;
    push     = bus.loadIR & (~is_full | pop);
    drop     = bus.loadIR & ~push;
  end

  // Next pointer/count/overflow state; flush overrides any push or pop.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    cnt_nxt    = cnt;
    ovf_nxt    = ovf_q;
    if (bus.flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      cnt_nxt    = '0;
      ovf_nxt    = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_nxt = wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr_nxt = rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        cnt_nxt = cnt + CW'(1);
      end else if (pop && !push) begin
        cnt_nxt = cnt - CW'(1);
      end
      if (drop) begin
        ovf_nxt = 1'b1;
      end
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      cnt    <= cnt_nxt;
      ovf_q  <= ovf_nxt;
    end
  end

  // Opcode storage; not reset since valid masks any stale entry.
  always_ff @(posedge clk) begin
    if (push && !bus.flush) begin
      mem[wr_ptr] <= bus.inop;
    end
  end

  assign bus.opcode = is_valid ? mem[rd_ptr] : '0;
  assign bus.valid  = is_valid;
  assign bus.full   = is_full;
  assign bus.count  = cnt;
  assign bus.ovf    = ovf_q;

`ifdef IR_PARITY_EN
  logic par_mem [DEPTH];
  logic head_par;

  // Parity bit stored alongside each opcode.
  always_ff @(posedge clk) begin
    if (push && !bus.flush) begin
      par_mem[wr_ptr] <= bus.inpar;
    end
  end

  assign head_par = is_valid ? par_mem[rd_ptr] : 1'b0;
  assign bus.perr = is_valid & (^bus.opcode ^ head_par);
`else
  logic unused_inpar;

  assign unused_inpar = bus.inpar;
  assign bus.perr     = 1'b0;
`endif

endmodule

// File: tb/tb_ir_queue.sv
// Scoreboard bench for ir_queue: expected opcodes queued on accepted pushes,
// compared against the head when the consumer pops.
module tb_ir_queue;
  localparam int unsigned OP_W  = 6;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ir_queue_if #(.OP_W(OP_W), .DEPTH(DEPTH)) bus ();
  ir_queue #(.OP_W(OP_W), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  logic [OP_W-1:0] exp_q [$];
  logic            exp_par [$];
  logic            exp_ovf;

  function automatic logic [OP_W-1:0] exp_head();
    return (exp_q.size() != 0) ? exp_q[0] : '0;
  endfunction

  function automatic logic exp_perr();
`ifdef IR_PARITY_EN
    if (exp_q.size() == 0) return 1'b0;
    return ^exp_q[0] ^ exp_par[0];
`else
    return 1'b0;
`endif
  endfunction

  // Drive one cycle of stimulus and advance the reference model at the edge.
  task automatic step(input logic ld, input logic [OP_W-1:0] op, input logic par,
                      input logic nx, input logic fl);
    bit is_full, do_pop, do_push;
    bus.loadIR = ld;
    bus.inop   = op;
    bus.inpar  = par;
    bus.next   = nx;
    bus.flush  = fl;
    is_full = (exp_q.size() == DEPTH);
    do_pop  = nx && (exp_q.size() != 0);
    do_push = ld && (!is_full || do_pop);
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
      exp_par.delete();
      exp_ovf = 1'b0;
    end else begin
      if (do_pop) begin
        void'(exp_q.pop_front());
        void'(exp_par.pop_front());
      end
      if (do_push) begin
        exp_q.push_back(op);
        exp_par.push_back(par);
      end
      if (ld && !do_push) exp_ovf = 1'b1;
    end
    #1;
    bus.loadIR = 1'b0;
    bus.next   = 1'b0;
    bus.flush  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.loadIR = 1'b0; bus.inop = '0; bus.inpar = 1'b0; bus.next = 1'b0; bus.flush = 1'b0;
    exp_q.delete(); exp_par.delete(); exp_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.valid !== 1'b0 || bus.opcode !== '0 || bus.count !== '0 || bus.full !== 1'b0 ||
        bus.ovf !== 1'b0 || bus.perr !== 1'b0) begin
      errors++;
      $display("FAIL reset: valid=%b opcode=%h count=%0d full=%b ovf=%b perr=%b, required all zero",
               bus.valid, bus.opcode, bus.count, bus.full, bus.ovf, bus.perr);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_first_push();
    step(1'b1, 6'b000110, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.opcode !== 6'b000110 || bus.valid !== 1'b1 || bus.count !== CW'(1)) begin
      errors++;
      $display("FAIL first_push: opcode=%h valid=%b count=%0d, required 06 1 1",
               bus.opcode, bus.valid, bus.count);
    end
    checks++;
    if (bus.opcode !== exp_head()) begin
      errors++;
      $display("FAIL first_push_pop: opcode=%h required %h", bus.opcode, exp_head());
    end
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.valid !== 1'b0 || bus.opcode !== '0) begin
      errors++;
      $display("FAIL first_push_empty: valid=%b opcode=%h, required 0 00", bus.valid, bus.opcode);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 4; i++) step(1'b1, OP_W'(i), 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.full !== 1'b1 || bus.count !== CW'(4) || bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL fill: full=%b count=%0d ovf=%b, required 1 4 0", bus.full, bus.count, bus.ovf);
    end
    step(1'b1, 6'd5, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.ovf !== 1'b1 || bus.count !== CW'(4) || bus.opcode !== 6'd1) begin
      errors++;
      $display("FAIL overflow_drop: ovf=%b count=%0d opcode=%h, required 1 4 01",
               bus.ovf, bus.count, bus.opcode);
    end
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (bus.opcode !== exp_head() || bus.opcode !== OP_W'(i)) begin
        errors++;
        $display("FAIL fill_pop%0d: opcode=%h required %h", i, bus.opcode, OP_W'(i));
      end
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    end
    checks++;
    if (bus.valid !== 1'b0 || bus.opcode !== '0 || bus.count !== '0 || bus.ovf !== 1'b1) begin
      errors++;
      $display("FAIL drained: valid=%b opcode=%h count=%0d ovf=%b, required 0 00 0 1",
               bus.valid, bus.opcode, bus.count, bus.ovf);
    end
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.count !== '0 || bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL pop_empty: count=%0d valid=%b, required 0 0", bus.count, bus.valid);
    end
  endtask

  task automatic test_push_pop_full();
    logic [OP_W-1:0] want [4] = '{6'd2, 6'd3, 6'd4, 6'd7};
    for (int i = 1; i <= 4; i++) step(1'b1, OP_W'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 6'd7, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.count !== CW'(4) || bus.full !== 1'b1 || bus.opcode !== 6'd2) begin
      errors++;
      $display("FAIL pushpop_full: count=%0d full=%b opcode=%h, required 4 1 02",
               bus.count, bus.full, bus.opcode);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.opcode !== exp_head() || bus.opcode !== want[i]) begin
        errors++;
        $display("FAIL wrap_pop%0d: opcode=%h required %h", i, bus.opcode, want[i]);
      end
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    end
    step(1'b1, 6'd11, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.count !== CW'(1) || bus.opcode !== 6'd11) begin
      errors++;
      $display("FAIL push_next_empty: count=%0d opcode=%h, required 1 0b", bus.count, bus.opcode);
    end
    step(1'b1, 6'd12, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.count !== CW'(1) || bus.opcode !== 6'd12) begin
      errors++;
      $display("FAIL pushpop_one: count=%0d opcode=%h, required 1 0c", bus.count, bus.opcode);
    end
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_flush();
    for (int i = 1; i <= 5; i++) step(1'b1, OP_W'(20 + i), 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.count !== CW'(3) || bus.ovf !== 1'b1) begin
      errors++;
      $display("FAIL flush_setup: count=%0d ovf=%b, required 3 1", bus.count, bus.ovf);
    end
    step(1'b1, 6'd33, 1'b0, 1'b1, 1'b1);
    checks++;
    if (bus.count !== '0 || bus.valid !== 1'b0 || bus.ovf !== 1'b0 || bus.opcode !== '0) begin
      errors++;
      $display("FAIL flush: count=%0d valid=%b ovf=%b opcode=%h, required 0 0 0 00",
               bus.count, bus.valid, bus.ovf, bus.opcode);
    end
  endtask

  task automatic test_parity();
    logic want;
    step(1'b1, 6'b000111, 1'b0, 1'b0, 1'b0);
`ifdef IR_PARITY_EN
    want = 1'b1;
`else
    want = 1'b0;
`endif
    checks++;
    if (bus.perr !== want || bus.perr !== exp_perr()) begin
      errors++;
      $display("FAIL parity_bad: perr=%b required %b", bus.perr, want);
    end
    step(1'b1, 6'b000111, 1'b1, 1'b1, 1'b0);
    checks++;
    if (bus.perr !== 1'b0 || bus.opcode !== 6'b000111) begin
      errors++;
      $display("FAIL parity_good: perr=%b opcode=%h, required 0 07", bus.perr, bus.opcode);
    end
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic ld, nx, fl, par;
    logic [OP_W-1:0] op;
    for (int i = 0; i < 300; i++) begin
      ld  = 1'($urandom_range(0, 3) != 0);
      nx  = 1'($urandom_range(0, 2) != 0);
      fl  = 1'($urandom_range(0, 40) == 0);
      par = 1'($urandom);
      op  = OP_W'($urandom);
      step(ld, op, par, nx, fl);
      checks++;
      if (bus.opcode !== exp_head() || bus.count !== CW'(exp_q.size()) ||
          bus.valid !== (exp_q.size() != 0) || bus.full !== (exp_q.size() == DEPTH) ||
          bus.ovf !== exp_ovf || bus.perr !== exp_perr()) begin
        errors++;
        $display("FAIL b2b[%0d]: opcode=%h count=%0d valid=%b full=%b ovf=%b perr=%b, required %h %0d %b %b %b %b",
                 i, bus.opcode, bus.count, bus.valid, bus.full, bus.ovf, bus.perr,
                 exp_head(), exp_q.size(), exp_q.size() != 0, exp_q.size() == DEPTH,
                 exp_ovf, exp_perr());
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 1; i <= 5; i++) step(1'b1, OP_W'(40 + i), 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.count !== CW'(2) || bus.ovf !== 1'b1) begin
      errors++;
      $display("FAIL async_setup: count=%0d ovf=%b, required 2 1", bus.count, bus.ovf);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.count !== '0 || bus.valid !== 1'b0 || bus.opcode !== '0 || bus.ovf !== 1'b0 ||
        bus.full !== 1'b0 || bus.perr !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: count=%0d valid=%b opcode=%h ovf=%b, required all zero",
               bus.count, bus.valid, bus.opcode, bus.ovf);
    end
    exp_q.delete(); exp_par.delete(); exp_ovf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 6'd9, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.opcode !== 6'd9 || bus.count !== CW'(1) || bus.valid !== 1'b1) begin
      errors++;
      $display("FAIL after_reset_push: opcode=%h count=%0d valid=%b, required 09 1 1",
               bus.opcode, bus.count, bus.valid);
    end
  endtask

  initial begin
    test_reset();
    test_first_push();
    test_fill_overflow();
    test_push_pop_full();
    test_flush();
    test_parity();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
